// File: rtl/rs232_tx_scheduler_pkg.sv
// Shared types and constants for the RS232 transmit scheduler and its gap timer.
package rs232_tx_scheduler_pkg;

  // Scheduler state encoding; CHECK is reserved and never entered.
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GAP   = 3'd2,
    ST_ACK   = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  // Default inter-byte gap lengths in clock cycles (before the fixed 2-cycle overhead).
  localparam int rs232_delay       = 10;
  localparam int rs232_extra_delay = 20;

  // Gap timer counter width and state encoding.
  localparam int TIMER_W = 16;
  typedef enum logic {
    TM_IDLE = 1'b0,
    TM_RUN  = 1'b1
  } timer_state_t;

  // True when a byte needs the extended gap after it.
  function automatic logic needs_extra(input logic [7:0] b, input logic [7:0] marker);
    return (b == marker);
  endfunction

endpackage

// File: rtl/rs232_tx_scheduler_if.sv
// Requester/UART-side signal bundle of the RS232 transmit scheduler.
interface rs232_tx_scheduler_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ack_a;
  logic       ack_b;
  logic       busy;
  logic [2:0] state;

  // Environment side: requesters and the UART ready flag.
  modport master (
    output req_a, data_a, req_b, data_b, tx_ready,
    input  tx_data, tx_start, ack_a, ack_b, busy, state
  );

  // Scheduler side.
  modport slave (
    input  req_a, data_a, req_b, data_b, tx_ready,
    output tx_data, tx_start, ack_a, ack_b, busy, state
  );
endinterface

// File: rtl/rs232_timer.sv
// One-shot gap timer: after a start pulse, emits a one-cycle done pulse
// DELAY (or DELAY + EXTRA_DELAY) cycles after it latched the start.
module rs232_timer
  import rs232_tx_scheduler_pkg::*;
#(
  parameter int DELAY       = rs232_delay,
  parameter int EXTRA_DELAY = rs232_extra_delay
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         extra_delay,
  output logic         done,
  output timer_state_t state
);

  // Count loads minus one because the terminal-count cycle itself raises done.
  localparam logic [TIMER_W-1:0] LOAD_NORM = TIMER_W'(DELAY - 1);
  localparam logic [TIMER_W-1:0] LOAD_EXT  = TIMER_W'(DELAY + EXTRA_DELAY - 1);

  logic [TIMER_W-1:0] cnt_reg;

  // Load on start, count down while running, pulse done at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= TM_IDLE;
      cnt_reg <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TM_IDLE: begin
          if (start) begin
            cnt_reg <= extra_delay ? LOAD_EXT : LOAD_NORM;
            state   <= TM_RUN;
          end
        end
        TM_RUN: begin
          if (cnt_reg == '0) begin
            done  <= 1'b1;
            state <= TM_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state <= TM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from two requesters into a UART,
// enforcing a timed gap (longer after the marker byte) before acknowledging.
module rs232_tx_scheduler
  import rs232_tx_scheduler_pkg::*;
#(
  parameter logic [7:0] EXTRA_DELAY_CHAR  = 8'h0D,
  parameter int         RS232_DELAY       = rs232_delay,
  parameter int         RS232_EXTRA_DELAY = rs232_extra_delay
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rs232_tx_scheduler_if.slave   bus
);

  state_t     state_reg;
  logic [7:0] tx_data_reg;
  logic       tx_start_reg;
  logic       ack_a_reg;
  logic       ack_b_reg;
  logic       busy_reg;
  logic       last_b_reg;      // 1: B was served last, so A wins a tie
  logic       grant_a_reg;     // requester owning the byte in flight
  logic       timer_start_reg;
  logic       extra_reg;
  logic       timer_done;

  // The timer's debug state has no consumer here.
  timer_state_t timer_state_unused;

  rs232_timer #(
    .DELAY       (RS232_DELAY),
    .EXTRA_DELAY (RS232_EXTRA_DELAY)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (timer_start_reg),
    .extra_delay (extra_reg),
    .done        (timer_done),
    .state       (timer_state_unused)
  );

  // Grant, hand the byte to the UART, wait out the gap, then acknowledge for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      tx_data_reg     <= 8'h00;
      tx_start_reg    <= 1'b0;
      ack_a_reg       <= 1'b0;
      ack_b_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      last_b_reg      <= 1'b1;
      grant_a_reg     <= 1'b0;
      timer_start_reg <= 1'b0;
      extra_reg       <= 1'b0;
    end else begin
      tx_start_reg    <= 1'b0;
      timer_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_a || bus.req_b) begin
            if (bus.req_a && (!bus.req_b || last_b_reg)) begin
              grant_a_reg <= 1'b1;
              tx_data_reg <= bus.data_a;
              extra_reg   <= needs_extra(bus.data_a, EXTRA_DELAY_CHAR);
            end else begin
              grant_a_reg <= 1'b0;
              tx_data_reg <= bus.data_b;
              extra_reg   <= needs_extra(bus.data_b, EXTRA_DELAY_CHAR);
            end
            busy_reg  <= 1'b1;
            state_reg <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            tx_start_reg    <= 1'b1;
            timer_start_reg <= 1'b1;
            state_reg       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer_done) begin
            ack_a_reg  <= grant_a_reg;
            ack_b_reg  <= !grant_a_reg;
            last_b_reg <= !grant_a_reg;
            state_reg  <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_a_reg <= 1'b0;
          ack_b_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          ack_a_reg <= 1'b0;
          ack_b_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_start = tx_start_reg;
  assign bus.ack_a    = ack_a_reg;
  assign bus.ack_b    = ack_b_reg;
  assign bus.busy     = busy_reg;
  assign bus.state    = state_reg;

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Directed bench for rs232_tx_scheduler with gap lengths 10 / 20 cycles.
module tb_rs232_tx_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  rs232_tx_scheduler_if bus ();

  rs232_tx_scheduler #(
    .EXTRA_DELAY_CHAR  (8'h0D),
    .RS232_DELAY       (10),
    .RS232_EXTRA_DELAY (20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for tx_start; latency counted in cycles from the sample where the request was raised.
  task automatic wait_start(input string tag, input int exp_lat, input logic [7:0] exp_data);
    int  n = 0;
    bit  seen = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      tick();
      if (bus.tx_start) begin
        seen = 1;
        n = i;
      end
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
    if (exp_lat > 0) check({tag, "_start_latency"}, n, exp_lat);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'(exp_data));
  endtask

  // Wait for the requester's ack, drop requests, then check ack width and return to idle.
  task automatic wait_ack(input string tag, input bit is_a, input int exp_gap);
    int  n = 0;
    bit  seen = 0;
    bit  other = 0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      tick();
      if (is_a ? bus.ack_b : bus.ack_a) other = 1;
      if (is_a ? bus.ack_a : bus.ack_b) begin
        seen = 1;
        n = i;
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    check({tag, "_gap"}, n, exp_gap);
    check({tag, "_wrong_ack"}, 32'(other), 32'd0);
    tick();
    check({tag, "_ack_width"}, 32'(bus.ack_a | bus.ack_b), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_after"}, 32'(bus.state), 32'd0);
  endtask

  initial begin
    bit          bad;
    int          acks;
    int          starts;
    int          width_err;
    bit          prev_ack;
    bit          raise_a;
    bit          raise_b;
    logic [7:0]  got [4];
    logic [3:0]  ack_order;

    bus.req_a = 1'b0;
    bus.data_a = 8'h00;
    bus.req_b = 1'b0;
    bus.data_b = 8'h00;
    bus.tx_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_acks", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single byte from A
    bus.data_a = 8'h41;
    bus.req_a = 1'b1;
    wait_start("single_a", 2, 8'h41);
    wait_ack("single_a", 1'b1, 12);
    $display("single byte A 0x41 done");

    // Marker byte from B gets the extended gap
    bus.data_b = 8'h0D;
    bus.req_b = 1'b1;
    wait_start("extra_b", 2, 8'h0D);
    wait_ack("extra_b", 1'b0, 32);
    $display("extra-gap byte B 0x0D done");

    // Contention: both keep re-requesting; expect A, B, A, B
    bus.data_a = 8'h11;
    bus.data_b = 8'h22;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    acks = 0;
    starts = 0;
    width_err = 0;
    prev_ack = 0;
    raise_a = 0;
    raise_b = 0;
    ack_order = 4'b0000;
    for (int i = 0; i < 400 && acks < 4; i++) begin
      tick();
      if (raise_a) bus.req_a = 1'b1;
      if (raise_b) bus.req_b = 1'b1;
      raise_a = 0;
      raise_b = 0;
      if (bus.tx_start) begin
        if (starts < 4) got[starts] = bus.tx_data;
        starts++;
      end
      if (prev_ack && (bus.ack_a || bus.ack_b)) width_err++;
      prev_ack = bus.ack_a | bus.ack_b;
      if (bus.ack_a || bus.ack_b) begin
        ack_order[3 - acks] = bus.ack_a;
        acks++;
        if (bus.ack_a) begin
          bus.req_a = 1'b0;
          raise_a = (acks < 3);
        end
        if (bus.ack_b) begin
          bus.req_b = 1'b0;
          raise_b = (acks < 3);
        end
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    tick();
    check("cont_acks", acks, 4);
    check("cont_starts", starts, 4);
    check("cont_ack_order", 32'(ack_order), 32'b1010);
    check("cont_byte0", 32'(got[0]), 32'h11);
    check("cont_byte1", 32'(got[1]), 32'h22);
    check("cont_byte2", 32'(got[2]), 32'h11);
    check("cont_byte3", 32'(got[3]), 32'h22);
    check("cont_ack_width", width_err, 0);
    check("cont_idle", 32'(bus.busy), 32'd0);
    $display("contention A,B,A,B done");

    // Backpressure: UART not ready for 50 cycles after grant
    bus.tx_ready = 1'b0;
    bus.data_a = 8'h5A;
    bus.req_a = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.tx_start || !bus.busy || bus.state != 3'd1 || bus.tx_data != 8'h5A) bad = 1;
    end
    check("bp_hold", 32'(bad), 32'd0);
    bus.tx_ready = 1'b1;
    tick();
    check("bp_start", 32'(bus.tx_start), 32'd1);
    check("bp_tx_data", 32'(bus.tx_data), 32'h5A);
    wait_ack("bp_a", 1'b1, 12);
    $display("backpressure byte A 0x5A done");

    // Reset in the middle of a gap
    bus.data_b = 8'h33;
    bus.req_b = 1'b1;
    wait_start("rst_mid_b", 2, 8'h33);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ack_a || bus.ack_b) bad = 1;
    end
    bus.req_b = 1'b0;
    check("rst_mid_in_gap", 32'(bus.state), 32'd2);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(bus.state), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_tx_data", 32'(bus.tx_data), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    if (bus.ack_a || bus.ack_b) bad = 1;
    check("rst_mid_no_ack", 32'(bad), 32'd0);
    check("rst_mid_idle", 32'(bus.state), 32'd0);
    bus.data_a = 8'h44;
    bus.data_b = 8'h55;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    wait_start("post_rst", 2, 8'h44);
    wait_ack("post_rst_a", 1'b1, 12);
    $display("reset mid-gap and A-priority recovery done");

    // Quiet after everything is dropped
    repeat (5) tick();
    check("final_idle", 32'({bus.busy, bus.tx_start, bus.ack_a, bus.ack_b}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs232_tx_scheduler.md
RS232_TX_SCHEDULER -- requirements
Module: rs232_tx_scheduler

Interface
REQ-001 Parameter: EXTRA_DELAY_CHAR, default 8'h0D; a granted byte equal to this value SHALL get the extended inter-byte gap.
REQ-002 Port: clk  input  1  master clock, 50 MHz.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_a  input  1  requester A wants to send data_a; held high until ack_a.
REQ-005 Port: data_a  input  8  byte from requester A; stable while req_a is high.
REQ-006 Port: req_b  input  1  requester B wants to send data_b; held high until ack_b.
REQ-007 Port: data_b  input  8  byte from requester B; stable while req_b is high.
REQ-008 Port: tx_ready  input  1  UART transmitter idle, able to accept a byte.
REQ-009 Port: tx_data  output  8  byte presented to the UART.
REQ-010 Port: tx_start  output  1  one-cycle strobe; the UART loads tx_data.
REQ-011 Port: ack_a  output  1  one-cycle pulse; A's byte has been sent and its gap has elapsed.
REQ-012 Port: ack_b  output  1  one-cycle pulse; B's byte has been sent and its gap has elapsed.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: state  output  3  current FSM state, for debug.

Function
REQ-015 The FSM SHALL have five states:
- IDLE = 0
- SEND = 1
- GAP = 2
- ACK = 3
- CHECK = 4 (reserved; never entered, decodes to IDLE)
REQ-016 In IDLE, with any req high, the block SHALL grant one requester, latch its byte into tx_data, latch extra = (byte == EXTRA_DELAY_CHAR), and go to SEND.
REQ-017 Arbitration SHALL be round-robin: if both req are high, grant the requester not served last; after reset A has priority.
REQ-018 In SEND, when tx_ready is high, the block SHALL pulse tx_start for one cycle, pulse the timer start for the same cycle with extra_delay = latched extra, and go to GAP.
REQ-019 While tx_ready is low in SEND, the block SHALL wait indefinitely with tx_data held.
REQ-020 In GAP, the block SHALL wait for the timer done pulse, then set the granted ack high, record the served requester as last, and go to ACK.
REQ-021 In ACK, the block SHALL clear ack and return to IDLE, so each ack is exactly one cycle wide.
REQ-022 A requester SHALL deassert req in the cycle it sees ack high; a req still high in IDLE is treated as a new byte.
REQ-023 Changes on req or data during SEND, GAP or ACK SHALL be ignored.
REQ-024 The gap from tx_start to ack SHALL be the timer delay plus 2 cycles, or the timer delay plus extra delay plus 2 cycles when extra is set.

Reset
REQ-025 On reset_n low, independent of clk, the block SHALL set:
- state = IDLE
- tx_data = 8'h00
- tx_start = 0, ack_a = 0, ack_b = 0, busy = 0
- last-served = B (so A wins first)
- timer start = 0, extra = 0
REQ-026 A reset in mid-operation SHALL abort the transfer with no ack and SHALL also reset the sub-module timer.

Structure
REQ-027 State codes, the state width (3), and the timer delay constants rs232_delay and rs232_extra_delay SHALL live in parameters_global.v.
REQ-028 The block SHALL instantiate exactly one rs232_timer to generate the gaps.
REQ-029 rs232_timer SHALL share clk and reset_n with this block; its state output SHALL be left unconnected.

Verification (bench sets rs232_delay = 10, rs232_extra_delay = 20)
REQ-030 Single byte: req_a = 1, data_a = 8'h41, tx_ready = 1 -> tx_start 2 cycles later with tx_data = 8'h41; ack_a 12 cycles after tx_start; ack_b never.
REQ-031 Extra gap: req_b = 1, data_b = 8'h0D -> ack_b 32 cycles after tx_start.
REQ-032 Contention: req_a and req_b both held with repeated requests -> bytes sent in order A, B, A, B; no requester granted twice in a row.
REQ-033 Backpressure: tx_ready = 0 for 50 cycles after grant -> no tx_start and busy = 1; tx_start comes the cycle after tx_ready rises.
REQ-034 Reset mid-GAP: reset_n pulsed low -> state = 0, busy = 0, no ack; the next request completes normally with A priority.
REQ-035 Ack width: every ack_a and ack_b pulse is exactly 1 cycle, and busy returns to 0 the cycle after the ack.
